// File: rtl/uart_baud_div.sv
// Baud-rate tick generator: integer(+fraction) clock divider producing oversampling ticks,
// bit ticks and sub-bit phase. Define UART_BAUD_FRAC_EN to include the fractional accumulator.
module uart_baud_div #(
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4,
  parameter int OVS        = 16,
  parameter int RESET_DIV  = 325,
  parameter int RESET_FRAC = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic                   load,
  input  logic [DIV_W-1:0]       div_int,
  input  logic [FRAC_W-1:0]      div_frac,
  input  logic                   sync,
  output logic                   tick_ovs,
  output logic                   tick_baud,
  output logic [$clog2(OVS)-1:0] phase
);
  localparam int PH_W = $clog2(OVS);

  logic [DIV_W-1:0] cnt_reg, cnt_next;
  logic [PH_W-1:0]  phase_reg, phase_next;
  logic             tick_ovs_reg, tick_ovs_next;
  logic             tick_baud_reg, tick_baud_next;
  logic [DIV_W-1:0] act_int_reg, act_int_next;
  logic [DIV_W-1:0] pend_int_reg, pend_int_next;
  logic             pend_reg, pend_next;
  logic             run_reg;
  logic             carry;
  logic [DIV_W:0]   period;
  logic             terminal;
  logic             apply;

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] acc_reg, acc_next;
  logic [FRAC_W-1:0] act_frac_reg, act_frac_next;
  logic [FRAC_W-1:0] pend_frac_reg, pend_frac_next;
  logic              carry_reg, carry_next;

  assign carry = carry_reg;
`else
  logic frac_unused;

  assign carry       = 1'b0;
  assign frac_unused = ^{div_frac, RESET_FRAC[0]};
`endif

  assign period   = {1'b0, act_int_reg} + {{DIV_W{1'b0}}, carry};
  assign terminal = (({1'b0, cnt_reg} + (DIV_W+1)'(1)) == period);

  always_comb begin
    cnt_next       = cnt_reg;
    phase_next     = phase_reg;
    tick_ovs_next  = 1'b0;
    tick_baud_next = 1'b0;
    act_int_next   = act_int_reg;
    pend_int_next  = pend_int_reg;
    pend_next      = pend_reg;
    apply          = 1'b0;
`ifdef UART_BAUD_FRAC_EN
    acc_next       = acc_reg;
    carry_next     = carry_reg;
    act_frac_next  = act_frac_reg;
    pend_frac_next = pend_frac_reg;
`endif

    if (load) begin
      pend_int_next = div_int;
      pend_next     = 1'b1;
`ifdef UART_BAUD_FRAC_EN
      pend_frac_next = div_frac;
`endif
    end

    if (!en) begin
      cnt_next   = '0;
      phase_next = '0;
      apply      = pend_next;
`ifdef UART_BAUD_FRAC_EN
      acc_next   = '0;
      carry_next = 1'b0;
`endif
    end else if (sync || !run_reg) begin
      // The first enabled edge restarts like sync, so the first tick lands P edges later.
      cnt_next   = '0;
      phase_next = '0;
`ifdef UART_BAUD_FRAC_EN
      acc_next   = '0;
      carry_next = 1'b0;
`endif
    end else if (act_int_reg == '0) begin
      // Halted: no period is in progress, so a pending divisor takes effect at once.
      cnt_next = '0;
      apply    = pend_next;
    end else if (terminal) begin
      cnt_next       = '0;
      tick_ovs_next  = 1'b1;
      tick_baud_next = (phase_reg == PH_W'(OVS - 1));
      phase_next     = phase_reg + PH_W'(1);
      apply          = pend_next;
`ifdef UART_BAUD_FRAC_EN
      {carry_next, acc_next} = {1'b0, acc_reg} + {1'b0, act_frac_reg};
`endif
    end else begin
      cnt_next = cnt_reg + DIV_W'(1);
    end

    if (apply) begin
      act_int_next = pend_int_next;
      pend_next    = 1'b0;
`ifdef UART_BAUD_FRAC_EN
      act_frac_next = pend_frac_next;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg       <= '0;
      phase_reg     <= '0;
      tick_ovs_reg  <= 1'b0;
      tick_baud_reg <= 1'b0;
      act_int_reg   <= DIV_W'(RESET_DIV);
      pend_int_reg  <= '0;
      pend_reg      <= 1'b0;
      run_reg       <= 1'b0;
    end else begin
      cnt_reg       <= cnt_next;
      phase_reg     <= phase_next;
      tick_ovs_reg  <= tick_ovs_next;
      tick_baud_reg <= tick_baud_next;
      act_int_reg   <= act_int_next;
      pend_int_reg  <= pend_int_next;
      pend_reg      <= pend_next;
      run_reg       <= en;
    end
  end

`ifdef UART_BAUD_FRAC_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_reg       <= '0;
      carry_reg     <= 1'b0;
      act_frac_reg  <= FRAC_W'(RESET_FRAC);
      pend_frac_reg <= '0;
    end else begin
      acc_reg       <= acc_next;
      carry_reg     <= carry_next;
      act_frac_reg  <= act_frac_next;
      pend_frac_reg <= pend_frac_next;
    end
  end
`endif

  assign tick_ovs  = tick_ovs_reg;
  assign tick_baud = tick_baud_reg;
  assign phase     = phase_reg;

endmodule

// File: tb/tb_uart_baud_div.sv
// Self-checking bench for uart_baud_div: directed steps plus randomized divisors, checked
// every cycle against a closed-form tick-time model.
`timescale 1ns/1ps
module tb_uart_baud_div;
  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OVS    = 16;
`ifdef UART_BAUD_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              en = 1'b0;
  logic              load = 1'b0;
  logic              sync = 1'b0;
  logic [DIV_W-1:0]  div_int = '0;
  logic [FRAC_W-1:0] div_frac = '0;
  logic              tick_ovs;
  logic              tick_baud;
  logic [3:0]        phase;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Reference model: divisor epoch starting at edge m_r with the accumulator at zero.
  // Tick j of the epoch is set at edge m_r + j*m_a + floor((j-1)*m_f / 2^FRAC_W).
  bit m_enabled;
  int m_r, m_a, m_f, m_j, m_ph;
  bit m_pend;
  int m_pa, m_pf;

  int dut_ticks[$];
  int baud_seen;

  always #5 clk = ~clk;

  uart_baud_div dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .load     (load),
    .div_int  (div_int),
    .div_frac (div_frac),
    .sync     (sync),
    .tick_ovs (tick_ovs),
    .tick_baud(tick_baud),
    .phase    (phase)
  );

  function automatic int eff_frac(int f);
    return FRAC_ON ? f : 0;
  endfunction

  function automatic int m_next();
    return m_r + m_j * m_a + ((m_j - 1) * m_f) / (1 << FRAC_W);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %0d expected %0d", tag, edge_n, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_enabled = 0; m_a = 325; m_f = eff_frac(8); m_pend = 0;
    m_ph = 0; m_r = 0; m_j = 1;
  endtask

  task automatic apply_pending();
    m_a = m_pa; m_f = m_pf; m_pend = 0;
  endtask

  task automatic step();
    logic exp_tick, exp_baud;
    exp_tick = 1'b0;
    exp_baud = 1'b0;
    @(posedge clk);
    edge_n++;
    if (load) begin
      m_pend = 1; m_pa = int'(div_int); m_pf = eff_frac(int'(div_frac));
    end
    if (!en) begin
      m_enabled = 0; m_ph = 0;
      if (m_pend) apply_pending();
    end else if (sync || !m_enabled) begin
      m_enabled = 1; m_r = edge_n; m_j = 1; m_ph = 0;
    end else if (m_a == 0) begin
      if (m_pend) begin apply_pending(); m_r = edge_n; m_j = 1; end
    end else if (edge_n == m_next()) begin
      exp_tick = 1'b1;
      m_ph = (m_ph + 1) % OVS;
      exp_baud = (m_ph == 0);
      m_j++;
      if (m_pend) begin apply_pending(); m_r = edge_n; m_j = 1; end
    end
    #1;
    if (tick_ovs === 1'b1) dut_ticks.push_back(edge_n);
    if (tick_baud === 1'b1) baud_seen++;
    check("tick_ovs", 32'(tick_ovs), 32'(exp_tick));
    check("tick_baud", 32'(tick_baud), 32'(exp_baud));
    check("phase", 32'(phase), m_ph);
  endtask

  task automatic pulse_load(int a, int f);
    load = 1'b1; div_int = DIV_W'(a); div_frac = FRAC_W'(f);
    step();
    load = 1'b0;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_tick_ovs"}, 32'(tick_ovs), 0);
    check({tag, "_tick_baud"}, 32'(tick_baud), 0);
    check({tag, "_phase"}, 32'(phase), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, a, f, n, k;

    // Asynchronous reset, checked before any clock edge.
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) begin @(posedge clk); edge_n++; end
    #1 reset_n = 1'b1;
    model_reset();

    // 325/0: tick every 325 cycles, bit tick every 5200.
    pulse_load(325, 0);
    en = 1'b1;
    dut_ticks.delete(); baud_seen = 0;
    repeat (10500) step();
    check("t1_tick_count", 32'(dut_ticks.size()), 32);
    check("t1_baud_count", baud_seen, 2);

    // 27 + 2/16: sixteen periods span 434 cycles.
    en = 1'b0; step();
    pulse_load(27, 2);
    en = 1'b1;
    dut_ticks.delete();
    repeat (900) step();
    check("t2_enough_ticks", 32'(dut_ticks.size() >= 17), 1);
    if (dut_ticks.size() >= 17)
      check("t2_16_periods", dut_ticks[16] - dut_ticks[0], FRAC_ON ? 434 : 432);

    // Mid-period load: current 27-cycle period completes, then 10; later load overwrites.
    en = 1'b0; step();
    pulse_load(27, 0);
    en = 1'b1;
    t0 = edge_n + 1;
    repeat (40) step();
    dut_ticks.delete();
    pulse_load(5, 0);
    repeat (3) step();
    pulse_load(10, 0);
    repeat (60) step();
    check("t3_enough_ticks", 32'(dut_ticks.size() >= 2), 1);
    if (dut_ticks.size() >= 2) begin
      check("t3_old_period_end", dut_ticks[0] - t0, 54);
      check("t3_new_period", dut_ticks[1] - dut_ticks[0], 10);
    end

    // Sync on the terminal-count edge: no tick, phase 0, next tick act_int later.
    for (int i = 0; i < 40 && m_next() != edge_n + 1; i++) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("t4_sync_no_tick", 32'(tick_ovs), 0);
    check("t4_sync_phase", 32'(phase), 0);
    t0 = edge_n;
    dut_ticks.delete();
    repeat (25) step();
    check("t4_enough_ticks", 32'(dut_ticks.size() >= 1), 1);
    if (dut_ticks.size() >= 1) check("t4_after_sync", dut_ticks[0] - t0, 10);

    // Divisor 0 halts; divisor 1 ticks every cycle, bit tick every 16.
    pulse_load(0, 0);
    repeat (20) step();
    dut_ticks.delete();
    repeat (100) step();
    check("t5_halted", 32'(dut_ticks.size()), 0);
    pulse_load(1, 0);
    dut_ticks.delete(); baud_seen = 0;
    repeat (64) step();
    check("t5_every_cycle", 32'(dut_ticks.size()), 64);
    check("t5_baud_count", baud_seen, 4);

    // Reset mid-bit with a pending divisor: outputs clear, reset divisor resumes.
    pulse_load(200, 0);
    repeat (100) step();
    pulse_load(77, 0);
    repeat (5) step();
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("t6_reset");
    repeat (2) begin @(posedge clk); edge_n++; end
    #1 reset_n = 1'b1;
    model_reset();
    t0 = edge_n + 1;
    dut_ticks.delete();
    repeat (1000) step();
    check("t6_enough_ticks", 32'(dut_ticks.size() >= 3), 1);
    if (dut_ticks.size() >= 3) begin
      check("t6_first", dut_ticks[0] - t0, 325);
      check("t6_second", dut_ticks[1] - dut_ticks[0], 325);
      check("t6_third", dut_ticks[2] - dut_ticks[1], FRAC_ON ? 326 : 325);
    end

    // Randomized divisors with a sync at a random point.
    for (int it = 0; it < 6; it++) begin
      a = int'($urandom_range(1, 40));
      f = int'($urandom_range(0, 15));
      n = int'($urandom_range(200, 600));
      k = int'($urandom_range(50, 199));
      en = 1'b0; step();
      pulse_load(a, f);
      en = 1'b1;
      for (int i = 0; i < n; i++) begin
        sync = (i == k);
        step();
      end
      sync = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
